// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: power-up initialisation, single-word closed-page
// reads/writes (ACT + READA/WRITA) and periodic auto-refresh, one command
// code per clock towards memory_interface. All outputs are registered.
module sdram_cmd_sequencer #(
    parameter int          INIT_WAIT    = 20000,
    parameter int          REF_INTERVAL = 780,
    parameter int          T_RP         = 2,
    parameter int          T_RC         = 7,
    parameter int          T_RCD        = 2,
    parameter int          T_MRD        = 2,
    parameter int          CAS_LAT      = 2,
    parameter logic [11:0] MRS_VALUE    = 12'h020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [21:0] req_addr,
    input  logic [1:0]  req_be,
    output logic        req_ready,
    output logic [3:0]  command,
    output logic [11:0] mrs,
    output logic [21:0] addr_out,
    output logic [1:0]  be_out,
    output logic        rd_strobe,
    output logic        wr_strobe,
    output logic        init_done
);

    localparam logic [3:0] CMD_NOP   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READA = 4'b0101;
    localparam logic [3:0] CMD_WRITA = 4'b0111;
    localparam logic [3:0] CMD_PALL  = 4'b1001;
    localparam logic [3:0] CMD_REF   = 4'b1011;

    // A "wait N" is the command cycle followed by N-1 NOP cycles, so the
    // down-counter is loaded with N-1 when the command is issued.
    localparam logic [15:0] INIT_WAIT_CNT = 16'(INIT_WAIT);
    localparam logic [15:0] WAIT_RP       = 16'(T_RP - 1);
    localparam logic [15:0] WAIT_RC       = 16'(T_RC - 1);
    localparam logic [15:0] WAIT_RCD      = 16'(T_RCD - 1);
    localparam logic [15:0] WAIT_RW       = 16'(T_RC - T_RCD - 1);
    localparam logic [15:0] WAIT_MRD      = 16'(T_MRD - 1);
    localparam logic [15:0] REF_LAST      = 16'(REF_INTERVAL - 1);

    // Each state names the action taken once the pending wait has elapsed.
    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MRS,
        S_TO_IDLE,
        S_IDLE,
        S_ACT,
        S_RW
    } state_t;

    state_t         state;
    logic [15:0]    wait_cnt;
    logic [15:0]    ref_cnt;
    logic           ref_pending;
    logic           ref_expire;
    logic           ref_pending_next;
    logic           lat_we;
    logic [21:0]    lat_addr;
    logic [1:0]     lat_be;
    logic [CAS_LAT:0] rd_pipe;

    assign mrs       = MRS_VALUE;
    assign rd_strobe = rd_pipe[CAS_LAT];

    // Refresh bookkeeping: a new expiry wins over the service clear, so an
    // expiry landing on the REF cycle is not lost.
    always_comb begin
        ref_expire       = init_done && (ref_cnt == REF_LAST);
        ref_pending_next = ref_pending;
        if (state == S_IDLE && ref_pending) begin
            ref_pending_next = 1'b0;
        end
        if (ref_expire) begin
            ref_pending_next = 1'b1;
        end
    end

    // Refresh interval counter and sticky pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_pending <= ref_pending_next;
            if (init_done) begin
                ref_cnt <= ref_expire ? 16'd0 : ref_cnt + 16'd1;
            end
        end
    end

    // Command FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT_WAIT;
            wait_cnt  <= '0;
            command   <= CMD_NOP;
            addr_out  <= '0;
            be_out    <= 2'b11;
            req_ready <= 1'b0;
            wr_strobe <= 1'b0;
            init_done <= 1'b0;
            rd_pipe   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= 2'b11;
        end else begin
            command   <= CMD_NOP;
            be_out    <= 2'b11;
            wr_strobe <= 1'b0;
            req_ready <= 1'b0;
            rd_pipe   <= {rd_pipe[CAS_LAT-1:0], 1'b0};
            if (state != S_INIT_WAIT && wait_cnt != 16'd0) begin
                wait_cnt <= wait_cnt - 16'd1;
            end else begin
                case (state)
                    S_INIT_WAIT: begin
                        if (wait_cnt == INIT_WAIT_CNT) begin
                            command  <= CMD_PALL;
                            wait_cnt <= WAIT_RP;
                            state    <= S_INIT_REF1;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end
                    S_INIT_REF1: begin
                        command  <= CMD_REF;
                        wait_cnt <= WAIT_RC;
                        state    <= S_INIT_REF2;
                    end
                    S_INIT_REF2: begin
                        command  <= CMD_REF;
                        wait_cnt <= WAIT_RC;
                        state    <= S_INIT_MRS;
                    end
                    S_INIT_MRS: begin
                        command  <= CMD_MRS;
                        wait_cnt <= WAIT_MRD;
                        state    <= S_TO_IDLE;
                    end
                    S_TO_IDLE: begin
                        state     <= S_IDLE;
                        init_done <= 1'b1;
                        req_ready <= !ref_pending_next;
                    end
                    S_IDLE: begin
                        if (ref_pending) begin
                            command  <= CMD_REF;
                            wait_cnt <= WAIT_RC;
                            state    <= S_TO_IDLE;
                        end else if (req_valid && req_ready) begin
                            lat_we   <= req_we;
                            lat_addr <= req_addr;
                            lat_be   <= req_be;
                            wait_cnt <= 16'd0;
                            state    <= S_ACT;
                        end else begin
                            req_ready <= !ref_pending_next;
                        end
                    end
                    S_ACT: begin
                        command  <= CMD_ACT;
                        addr_out <= lat_addr;
                        be_out   <= lat_be;
                        wait_cnt <= WAIT_RCD;
                        state    <= S_RW;
                    end
                    S_RW: begin
                        command    <= lat_we ? CMD_WRITA : CMD_READA;
                        addr_out   <= lat_addr;
                        be_out     <= lat_be;
                        wr_strobe  <= lat_we;
                        rd_pipe[0] <= !lat_we;
                        wait_cnt   <= WAIT_RW;
                        state      <= S_TO_IDLE;
                    end
                    default: begin
                        state <= S_INIT_WAIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer: randomized requests against a timestamp-based
// reference model; expected command events go into a queue that a separate
// monitor checks cycle by cycle.
module tb_sdram_cmd_sequencer;

    localparam int          INIT_WAIT    = 10;
    localparam int          REF_INTERVAL = 50;
    localparam int          T_RP         = 2;
    localparam int          T_RC         = 7;
    localparam int          T_RCD        = 2;
    localparam int          T_MRD        = 2;
    localparam int          CAS_LAT      = 2;
    localparam logic [11:0] MRS_VALUE    = 12'h020;

    localparam logic [3:0] NOP   = 4'b0001;
    localparam logic [3:0] MRSC  = 4'b0010;
    localparam logic [3:0] ACT   = 4'b0011;
    localparam logic [3:0] READA = 4'b0101;
    localparam logic [3:0] WRITA = 4'b0111;
    localparam logic [3:0] PALL  = 4'b1001;
    localparam logic [3:0] REF   = 4'b1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [21:0] req_addr;
    logic [1:0]  req_be;
    logic        req_ready;
    logic [3:0]  command;
    logic [11:0] mrs;
    logic [21:0] addr_out;
    logic [1:0]  be_out;
    logic        rd_strobe;
    logic        wr_strobe;
    logic        init_done;

    sdram_cmd_sequencer #(
        .INIT_WAIT(INIT_WAIT), .REF_INTERVAL(REF_INTERVAL), .T_RP(T_RP),
        .T_RC(T_RC), .T_RCD(T_RCD), .T_MRD(T_MRD), .CAS_LAT(CAS_LAT),
        .MRS_VALUE(MRS_VALUE)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_ready(req_ready),
        .command(command), .mrs(mrs), .addr_out(addr_out), .be_out(be_out),
        .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [21:0] addr;
        logic [1:0]  be;
        bit          rd;
        bit          wr;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = -2;
    bit  exp_ready;
    bit  exp_init;

    // reference model state (timestamps, not FSM states)
    int  m_idle_from;
    int  m_init_end;
    bit  m_pend;
    bit  m_ready;
    bit  accepted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    task automatic push_ev(input int c, input logic [3:0] cmd, input logic [21:0] a,
                           input logic [1:0] be, input bit rd, input bit wr);
        ev_t e;
        e.cyc = c; e.cmd = cmd; e.addr = a; e.be = be; e.rd = rd; e.wr = wr;
        exp_q.push_back(e);
    endtask

    // Power-up schedule derived from the wait rules; issued on each reset edge.
    task automatic model_reset();
        int t;
        exp_q.delete();
        m_pend    = 1'b0;
        m_ready   = 1'b0;
        exp_ready = 1'b0;
        exp_init  = 1'b0;
        t = INIT_WAIT;
        push_ev(t, PALL, 22'd0, 2'b11, 1'b0, 1'b0);
        t += T_RP;
        push_ev(t, REF, 22'd0, 2'b11, 1'b0, 1'b0);
        t += T_RC;
        push_ev(t, REF, 22'd0, 2'b11, 1'b0, 1'b0);
        t += T_RC;
        push_ev(t, MRSC, 22'd0, 2'b11, 1'b0, 1'b0);
        t += T_MRD;
        m_init_end  = t;
        m_idle_from = t;
    endtask

    // Behaviour at edge n, using the inputs the bench is currently driving.
    task automatic model_edge(input int n);
        accepted = 1'b0;
        if (n - 1 >= m_idle_from) begin
            if (m_pend) begin
                push_ev(n, REF, 22'd0, 2'b11, 1'b0, 1'b0);
                m_pend      = 1'b0;
                m_idle_from = n + T_RC;
            end else if (req_valid && m_ready) begin
                accepted = 1'b1;
                push_ev(n + 1, ACT, req_addr, req_be, 1'b0, 1'b0);
                push_ev(n + 1 + T_RCD, req_we ? WRITA : READA, req_addr, req_be, 1'b0, req_we);
                if (!req_we) push_ev(n + 1 + T_RCD + CAS_LAT, NOP, 22'd0, 2'b11, 1'b1, 1'b0);
                m_idle_from = n + 1 + T_RC;
                $display("accept cyc=%0d we=%0d addr=%06h be=%b", n, req_we, req_addr, req_be);
            end
        end
        if (n > m_init_end && ((n - m_init_end) % REF_INTERVAL) == 0) m_pend = 1'b1;
        m_ready   = (n >= m_idle_from) && !m_pend;
        exp_ready = m_ready;
        exp_init  = (n >= m_init_end);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            cyc = -1;
            model_reset();
        end else begin
            cyc++;
            model_edge(cyc);
        end
        @(negedge clk);
    endtask

    task automatic rand_fields();
        req_we   = 1'($urandom_range(0, 1));
        req_addr = 22'($urandom);
        req_be   = 2'($urandom_range(0, 3));
    endtask

    // Hold a request valid until the model accepts it (bounded).
    task automatic issue(input bit we, input logic [21:0] a, input logic [1:0] be);
        int budget;
        req_valid = 1'b1; req_we = we; req_addr = a; req_be = be;
        budget = 300;
        do begin
            step();
            budget--;
        end while (!accepted && budget > 0);
        if (!accepted) begin
            checks++; failures++;
            $display("FAIL accept_timeout cyc=%0d got=none want=accept", cyc);
        end
        req_valid = 1'b0;
        rand_fields();
    endtask

    task automatic run_random(input int count);
        for (int r = 0; r < count; r++) begin
            int gap;
            gap = $urandom_range(0, 12);
            for (int g = 0; g < gap; g++) begin
                rand_fields();
                step();
            end
            issue(1'($urandom_range(0, 1)), 22'($urandom), 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin : driver
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = 2'b11;
        repeat (3) step();
        rst = 1'b0;
        issue(1'b0, 22'h2ABC12, 2'b00);
        issue(1'b1, 22'h155AA5, 2'b10);
        run_random(40);
        // reset during the ACT wait of an in-flight request
        repeat (3) step();
        issue(1'b0, 22'h0F0F0F, 2'b01);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_random(6);
        repeat (20) step();
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (cyc == -1) begin
                chk("rst_command", 32'(command), 32'(NOP));
                chk("rst_init_done", 32'(init_done), 32'd0);
                chk("rst_req_ready", 32'(req_ready), 32'd0);
                chk("rst_be_out", 32'(be_out), 32'(2'b11));
                chk("rst_addr_out", 32'(addr_out), 32'd0);
                chk("rst_strobes", 32'({rd_strobe, wr_strobe}), 32'd0);
                chk("rst_mrs", 32'(mrs), 32'(MRS_VALUE));
            end else if (cyc >= 0) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++; failures++;
                    $display("FAIL missed_event cyc=%0d got=none want=cmd %b at %0d", cyc, e.cmd, e.cyc);
                end
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("command", 32'(command), 32'(e.cmd));
                    chk("be_out", 32'(be_out), 32'(e.be));
                    chk("rd_strobe", 32'(rd_strobe), 32'(e.rd));
                    chk("wr_strobe", 32'(wr_strobe), 32'(e.wr));
                    if (e.cmd == ACT || e.cmd == READA || e.cmd == WRITA)
                        chk("addr_out", 32'(addr_out), 32'(e.addr));
                    if (e.cmd == MRSC)
                        chk("mrs", 32'(mrs), 32'(MRS_VALUE));
                end else begin
                    chk("quiet_cycle", 32'({command, be_out, rd_strobe, wr_strobe}),
                        32'({NOP, 2'b11, 1'b0, 1'b0}));
                end
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("init_done", 32'(init_done), 32'(exp_init));
            end
        end
    end

endmodule
